// File: rtl/mips_mem_arbiter_if.sv
// CPU instruction/data ports and unified memory port of the MIPS memory arbiter.
// master = CPU + memory side, slave = arbiter.
interface mips_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  InstMem_Read;
  logic [ADDR_WIDTH-1:0] InstMem_Address;
  logic [DATA_WIDTH-1:0] InstMem_In;
  logic                  InstMem_Ready;

  logic                  DataMem_Read;
  logic [BW-1:0]         DataMem_Write;
  logic [ADDR_WIDTH-1:0] DataMem_Address;
  logic [DATA_WIDTH-1:0] DataMem_Out;
  logic [DATA_WIDTH-1:0] DataMem_In;
  logic                  DataMem_Ready;

  logic                  Mem_Read;
  logic [BW-1:0]         Mem_Write;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_Out;
  logic [DATA_WIDTH-1:0] Mem_In;
  logic                  Mem_Ready;

  modport master (
    output InstMem_Read, InstMem_Address,
    output DataMem_Read, DataMem_Write,
    output DataMem_Address, DataMem_Out,
    output Mem_In, Mem_Ready,
    input  InstMem_In, InstMem_Ready,
    input  DataMem_In, DataMem_Ready,
    input  Mem_Read, Mem_Write,
    input  Mem_Address, Mem_Out
  );

  modport slave (
    input  InstMem_Read, InstMem_Address,
    input  DataMem_Read, DataMem_Write,
    input  DataMem_Address, DataMem_Out,
    input  Mem_In, Mem_Ready,
    output InstMem_In, InstMem_Ready,
    output DataMem_In, DataMem_Ready,
    output Mem_Read, Mem_Write,
    output Mem_Address, Mem_Out
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Inst/data to unified memory arbiter, all outputs registered.
// MEM_ARB_ROUND_ROBIN_EN: alternate grants on collision (default: data wins).
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  mips_mem_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } state_t;

  typedef enum logic {
    LG_INST,
    LG_DATA
  } grant_t;

  state_t                r_state;
  grant_t                r_last;
  logic                  r_mem_read;
  logic [BW-1:0]         r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_out;
  logic [DATA_WIDTH-1:0] r_inst_in;
  logic                  r_inst_rdy;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_data_rdy;

  logic w_dwr;
  logic w_dreq;
  logic w_ireq;
  logic w_pick_d;

  // X/Z enables count as no write
  assign w_dwr  = ((|bus.DataMem_Write) === 1'b1);
  assign w_dreq = bus.DataMem_Read | w_dwr;
  assign w_ireq = bus.InstMem_Read;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_pick_d = w_dreq & (~w_ireq | (r_last == LG_INST));
`else
  logic w_unused_last;
  assign w_unused_last = r_last;
  assign w_pick_d      = w_dreq;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= LG_INST;
      r_mem_read  <= 1'b0;
      r_mem_write <= '0;
      r_mem_addr  <= '0;
      r_mem_out   <= '0;
      r_inst_in   <= '0;
      r_inst_rdy  <= 1'b0;
      r_data_in   <= '0;
      r_data_rdy  <= 1'b0;
    end else begin
      r_inst_rdy <= 1'b0;
      r_data_rdy <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= GRANT_D;
            r_mem_read  <= bus.DataMem_Read;
            r_mem_addr  <= bus.DataMem_Address;
            r_mem_out   <= bus.DataMem_Out;
            // a read with enables set is still a plain read
            r_mem_write <= (bus.DataMem_Read | ~w_dwr) ?
                           '0 : bus.DataMem_Write;
          end else if (w_ireq) begin
            r_state     <= GRANT_I;
            r_mem_read  <= 1'b1;
            r_mem_write <= '0;
            r_mem_addr  <= bus.InstMem_Address;
            r_mem_out   <= '0;
          end
        end
        GRANT_I: begin
          if (bus.Mem_Ready) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= '0;
            r_inst_in   <= bus.Mem_In;
            r_inst_rdy  <= 1'b1;
            r_last      <= LG_INST;
            r_state     <= RELEASE;
          end
        end
        GRANT_D: begin
          if (bus.Mem_Ready) begin
            if (r_mem_read) begin
              r_data_in <= bus.Mem_In;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= '0;
            r_data_rdy  <= 1'b1;
            r_last      <= LG_DATA;
            r_state     <= RELEASE;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Mem_Read      = r_mem_read;
  assign bus.Mem_Write     = r_mem_write;
  assign bus.Mem_Address   = r_mem_addr;
  assign bus.Mem_Out       = r_mem_out;
  assign bus.InstMem_In    = r_inst_in;
  assign bus.InstMem_Ready = r_inst_rdy;
  assign bus.DataMem_In    = r_data_in;
  assign bus.DataMem_Ready = r_data_rdy;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized bench for mips_mem_arbiter with a transaction-level model
// and a behavioural memory with random latency.
module tb_mips_mem_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] mem [16];
  int  cyc = 0;
  int  free_cyc = 0;
  int  lat = 0;
  int  fix_lat = -1;
  bit  stray_en = 0;
  bit  busy = 0;
  bit  cur_d, cur_rd, last_d;
  logic [AW-1:0] cur_a;
  logic [BW-1:0] cur_we;
  logic [DW-1:0] cur_out, rd_val, exp_iin, exp_din;

  logic s_rst, s_ir, s_dr;
  logic [BW-1:0] s_dw;
  logic [AW-1:0] s_ia, s_da;
  logic [DW-1:0] s_do;
  bit done, sd, exp_st, obs_st, pd;

  // memory model + transaction checker, samples 1 unit after each edge
  initial begin
    bus.Mem_Ready = 1'b0;
    bus.Mem_In = '0;
    last_d = 0;
    exp_iin = '0;
    exp_din = '0;
    forever begin
      @(posedge clock);
      s_rst = reset;
      s_ir = bus.InstMem_Read;
      s_dr = bus.DataMem_Read;
      s_dw = bus.DataMem_Write;
      s_ia = bus.InstMem_Address;
      s_da = bus.DataMem_Address;
      s_do = bus.DataMem_Out;
      #1;
      cyc++;
      done = busy && bus.Mem_Ready;
      bus.Mem_Ready = 1'b0;
      bus.Mem_In = $urandom;
      if (s_rst) begin
        chk("rst_mem", {bus.Mem_Read, bus.Mem_Write, bus.Mem_Address}, 0);
        chk("rst_mout", bus.Mem_Out, 0);
        chk("rst_rdy", {bus.InstMem_Ready, bus.DataMem_Ready}, 0);
        chk("rst_iin", bus.InstMem_In, 0);
        chk("rst_din", bus.DataMem_In, 0);
        busy = 0;
        last_d = 0;
        exp_iin = '0;
        exp_din = '0;
        free_cyc = cyc + 1;
      end else if (done) begin
        chk("rdy_i", bus.InstMem_Ready, !cur_d);
        chk("rdy_d", bus.DataMem_Ready, cur_d);
        chk("clr", {bus.Mem_Read, bus.Mem_Write}, 0);
        if (!cur_d) exp_iin = rd_val;
        else if (cur_rd) exp_din = rd_val;
        chk("inst_in", bus.InstMem_In, exp_iin);
        chk("data_in", bus.DataMem_In, exp_din);
        busy = 0;
        last_d = cur_d;
        free_cyc = cyc + 2;
      end else begin
        chk("no_rdy", {bus.InstMem_Ready, bus.DataMem_Ready}, 0);
        if (!busy) begin
          sd = s_dr || (s_dw != 0);
          exp_st = (cyc >= free_cyc) && (sd || s_ir);
          obs_st = bus.Mem_Read || (bus.Mem_Write != 0);
          chk("start", obs_st, exp_st);
          if (exp_st) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pd = (sd && s_ir) ? !last_d : sd;
`else
            pd = sd;
`endif
            cur_d = pd;
            cur_rd = pd ? s_dr : 1'b1;
            cur_a = pd ? s_da : s_ia;
            cur_we = (pd && !s_dr) ? s_dw : '0;
            cur_out = s_do;
            chk("g_addr", bus.Mem_Address, cur_a);
            chk("g_rd", bus.Mem_Read, cur_rd);
            chk("g_we", bus.Mem_Write, cur_we);
            if (!cur_rd) chk("g_out", bus.Mem_Out, cur_out);
            busy = 1;
            lat = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 3);
          end
        end else begin
          chk("hold", {bus.Mem_Read, bus.Mem_Write, bus.Mem_Address},
              {cur_rd, cur_we, cur_a});
        end
        if (busy) begin
          if (lat == 0) begin
            bus.Mem_Ready = 1'b1;
            if (cur_rd) begin
              rd_val = mem[cur_a[3:0]];
              bus.Mem_In = rd_val;
            end else begin
              for (int b = 0; b < BW; b++)
                if (bus.Mem_Write[b])
                  mem[cur_a[3:0]][8*b +: 8] = bus.Mem_Out[8*b +: 8];
            end
          end else begin
            lat--;
          end
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
          bus.Mem_Ready = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_rdy(input bit d, output bit ok);
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      ok = d ? bus.DataMem_Ready : bus.InstMem_Ready;
    end
    chk(d ? "wait_d" : "wait_i", ok, 1);
  endtask

  bit ok, got_i, got_d;
  int first, exp_first;

  initial begin
    bus.InstMem_Read = 0;
    bus.InstMem_Address = '0;
    bus.DataMem_Read = 0;
    bus.DataMem_Write = '0;
    bus.DataMem_Address = '0;
    bus.DataMem_Out = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h8C010004;
    repeat (3) tick();
    reset = 0;
    tick();

    // fetch only, memory answers 2 cycles after Mem_Read
    fix_lat = 2;
    bus.InstMem_Read = 1;
    bus.InstMem_Address = 30'h10;
    wait_rdy(0, ok);
    bus.InstMem_Read = 0;
    chk("f_data", bus.InstMem_In, 32'h8C010004);
    tick();
    chk("f_pulse", bus.InstMem_Ready, 0);

    // byte store
    fix_lat = 1;
    bus.DataMem_Write = 4'b0100;
    bus.DataMem_Address = 30'h800;
    bus.DataMem_Out = 32'h00AB0000;
    wait_rdy(1, ok);
    bus.DataMem_Write = '0;
    chk("st_mem", mem[0], 32'h8CAB0004);
    chk("st_din", bus.DataMem_In, 0);
    tick();

    // collision after a data access
    bus.InstMem_Read = 1;
    bus.InstMem_Address = 30'h20;
    bus.DataMem_Read = 1;
    bus.DataMem_Address = 30'h800;
    first = 2;
    got_i = 0;
    got_d = 0;
    for (int i = 0; i < 80 && !(got_i && got_d); i++) begin
      tick();
      if (bus.InstMem_Ready) begin
        got_i = 1;
        bus.InstMem_Read = 0;
        if (first == 2) first = 0;
      end
      if (bus.DataMem_Ready) begin
        got_d = 1;
        bus.DataMem_Read = 0;
        if (first == 2) first = 1;
      end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first = 0;
`else
    exp_first = 1;
`endif
    chk("col_done", {got_i, got_d}, 2'b11);
    chk("col_first", first, exp_first);
    chk("col_iin", bus.InstMem_In, 32'h8CAB0004);
    tick();

    // read with write enables set is a read
    bus.DataMem_Read = 1;
    bus.DataMem_Write = 4'hF;
    bus.DataMem_Address = 30'h5;
    bus.DataMem_Out = 32'hDEADBEEF;
    wait_rdy(1, ok);
    bus.DataMem_Read = 0;
    bus.DataMem_Write = '0;
    chk("rw_mem", mem[5] == 32'hDEADBEEF, 0);
    tick();

    // reset while GRANT_D waits on memory
    fix_lat = 50;
    bus.DataMem_Read = 1;
    bus.DataMem_Address = 30'h3;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = bus.Mem_Read;
    end
    chk("rm_grant", ok, 1);
    reset = 1;
    tick();
    reset = 0;
    bus.DataMem_Read = 0;
    chk("rm_rdy", bus.DataMem_Ready, 0);
    chk("rm_mrd", bus.Mem_Read, 0);
    fix_lat = 1;
    tick();
    bus.DataMem_Read = 1;
    wait_rdy(1, ok);
    bus.DataMem_Read = 0;
    chk("rm_data", bus.DataMem_In, mem[3]);

    // stray memory ready while idle
    stray_en = 1;
    repeat (12) tick();

    // random traffic
    fix_lat = -1;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (bus.InstMem_Ready) bus.InstMem_Read = 0;
      if (bus.DataMem_Ready) begin
        bus.DataMem_Read = 0;
        bus.DataMem_Write = '0;
      end
      if (!bus.InstMem_Read && $urandom_range(0, 2) == 0) begin
        bus.InstMem_Read = 1;
        bus.InstMem_Address = AW'($urandom_range(0, 15));
      end
      if (!bus.DataMem_Read && bus.DataMem_Write == 0 &&
          $urandom_range(0, 2) == 0) begin
        first = $urandom_range(0, 2);
        bus.DataMem_Read = (first != 1);
        bus.DataMem_Write = (first == 0) ? '0 : BW'($urandom_range(1, 15));
        bus.DataMem_Address = AW'($urandom_range(0, 15));
        bus.DataMem_Out = $urandom;
      end
    end

    bus.InstMem_Read = 0;
    bus.DataMem_Read = 0;
    bus.DataMem_Write = '0;
    stray_en = 0;
    repeat (12) tick();
    chk("drain", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Two-master to one-slave arbiter between the MIPS32 core's separate instruction and data memory interfaces and a single unified word-addressed memory port. It sits directly upstream of the memory model and serialises fetches, loads and stores onto one request/ready channel. It registers all memory-side outputs and returns read data plus a one-cycle Ready pulse to the requesting CPU port.

Parameters:
ADDR_WIDTH, 30, word-address width on all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8

Ports:
clock  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
InstMem_Read  input  1  CPU fetch request, held until InstMem_Ready
InstMem_Address  input  ADDR_WIDTH  fetch word address
InstMem_In  output  DATA_WIDTH  fetched instruction to CPU
InstMem_Ready  output  1  one-cycle fetch-complete pulse
DataMem_Read  input  1  CPU load request
DataMem_Write  input  4  CPU store byte enables (bit n = byte n)
DataMem_Address  input  ADDR_WIDTH  load/store word address
DataMem_Out  input  DATA_WIDTH  store data from CPU
DataMem_In  output  DATA_WIDTH  load data to CPU
DataMem_Ready  output  1  one-cycle load/store-complete pulse
Mem_Read  output  1  memory read request
Mem_Write  output  4  memory byte write enables
Mem_Address  output  ADDR_WIDTH  memory word address
Mem_Out  output  DATA_WIDTH  write data to memory
Mem_In  input  DATA_WIDTH  read data from memory
Mem_Ready  input  1  memory access complete

Behaviour:
- Reset: state IDLE. All outputs 0: Mem_Read, Mem_Write, Mem_Address, Mem_Out, InstMem_In, DataMem_In, InstMem_Ready, DataMem_Ready. last_grant = INST.
- Request decode: data request = DataMem_Read | (|DataMem_Write === 1). DataMem_Read together with nonzero Write is a read; the write is ignored. Write bits equal to X/Z mean no write. Inst request = InstMem_Read.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE: data request pending -> GRANT_D. Otherwise inst request pending -> GRANT_I. Otherwise stay.
- On grant (registered, same edge): latch address, Write (zeroed if read) and Out into Mem_*. Mem_Read = 1 for reads and for fetches.
- GRANT_x: hold Mem_* stable until Mem_Ready = 1 is sampled. At that edge:
  - clear Mem_Read and Mem_Write.
  - capture Mem_In into InstMem_In or DataMem_In; the capture is for reads only, and DataMem_In is unchanged for writes.
  - pulse the matching Ready for exactly 1 cycle.
  - go to RELEASE and update last_grant.
- Latency: request sampled at edge N; Mem_* asserted after N; Mem_Ready sampled at edge M; CPU Ready high in cycle M..M+1; back to IDLE at edge M+1; next grant at edge M+2 at the earliest. No combinational path from CPU inputs or Mem_Ready to any output.
- RELEASE: one dead cycle so the CPU can drop its request. Requests are ignored in this state. Go to IDLE.
- Mem_Ready outside GRANT_x is ignored. A duplicate memory access caused by one-cycle request overlap is tolerated: it is idempotent.
- CPU drops its request during GRANT_x: the transaction still completes and Ready still pulses.
- InstMem_Ready and DataMem_Ready are never high in the same cycle.
- Reset mid-transaction: the next edge returns all outputs to reset values. The transaction is abandoned and no Ready pulse is issued.
- Captured read data holds its value until the next read completion on the same port.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: when both requests are pending in IDLE, the grant goes to the port opposite last_grant; a single request is granted directly.
- Undefined: fixed priority, data always beats instruction. last_grant is still maintained but unused.

Test Plan:
- Fetch only: InstMem_Read=1, addr 0x10. Memory returns 0x8C010004 with Mem_Ready 2 cycles after Mem_Read rises -> Mem_Address=0x10, InstMem_In=0x8C010004, InstMem_Ready high for 1 cycle, DataMem_Ready stays 0.
- Byte store: DataMem_Write=4'b0100, addr 0x800, Out=0x00AB0000 -> Mem_Write=4'b0100, Mem_Out=0x00AB0000, Mem_Read=0. DataMem_Ready pulses once and DataMem_In is unchanged.
- Collision: both ports request in the same cycle (inst 0x20, data read 0x800) -> data served first. The inst grant follows exactly 1 RELEASE cycle later. With MEM_ARB_ROUND_ROBIN_EN and last_grant=DATA, inst is served first instead.
- Read+write conflict: DataMem_Read=1, DataMem_Write=4'hF -> Mem_Read=1, Mem_Write=0.
- Reset mid-op: assert reset while in GRANT_D before Mem_Ready -> all outputs 0 next cycle, no DataMem_Ready pulse, and the next request is served normally.
- Stray ready: Mem_Ready=1 while IDLE -> no Ready pulse, state stays IDLE.
